// File: rtl/router_pkg.sv
// Shared types and constants for the port scheduler slice.
package router_pkg;

  localparam int N_PORTS_DEF = 16;

  typedef logic [3:0] port_idx_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2
  } sched_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit at or after
// pointer, wrapping to the lowest set bit when none lies above pointer.
module rr_pick
  import router_pkg::*;
#(
  parameter int N_PORTS = N_PORTS_DEF
) (
  input  logic [N_PORTS-1:0] request,
  input  port_idx_t          pointer,
  output logic [N_PORTS-1:0] onehot,
  output port_idx_t          index
);

  logic [N_PORTS-1:0] upper_s;
  logic [N_PORTS-1:0] pick_src_s;
  logic [N_PORTS-1:0] onehot_s;
  port_idx_t          index_s;

  // Mask off ports below the pointer, fall back to the full vector on wrap,
  // then isolate the lowest set bit and encode its position.
  always_comb begin
    upper_s = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      upper_s[i] = request[i] & (i >= int'(pointer));
    end
    pick_src_s = (|upper_s) ? upper_s : request;
    onehot_s   = pick_src_s & (~pick_src_s + N_PORTS'(1));
    index_s    = 4'd0;
    for (int i = 0; i < N_PORTS; i++) begin
      index_s = index_s | (onehot_s[i] ? port_idx_t'(i) : 4'd0);
    end
  end

  assign onehot = onehot_s;
  assign index  = index_s;

endmodule

// File: rtl/port_scheduler.sv
// Output-port scheduler: round-robin grant held for a whole packet.
// Optional watchdog enabled by defining PORT_SCHED_TIMEOUT_EN.
module port_scheduler
  import router_pkg::*;
#(
  parameter int N_PORTS     = N_PORTS_DEF,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_PORTS-1:0] request,
  input  logic [N_PORTS-1:0] eop,
  input  logic               ready,
  output logic [N_PORTS-1:0] grant,
  output logic [3:0]         grant_id,
  output logic               busy,
  output logic               timeout_err
);

  sched_state_t       state_r;
  logic [N_PORTS-1:0] grant_r;
  port_idx_t          grant_id_r;
  logic               busy_r;
  port_idx_t          ptr_r;

  logic [N_PORTS-1:0] pick_onehot_s;
  port_idx_t          pick_index_s;
  logic               owner_req_s;
  logic               pkt_done_s;
  port_idx_t          ptr_next_s;

  rr_pick #(.N_PORTS(N_PORTS)) u_rr_pick (
    .request (request),
    .pointer (ptr_r),
    .onehot  (pick_onehot_s),
    .index   (pick_index_s)
  );

  // Packet end for the current owner: accepted eop beat or request withdrawn;
  // also the pointer value that resumes the search just past the owner.
  always_comb begin
    owner_req_s = request[grant_id_r];
    pkt_done_s  = ~owner_req_s | (ready & eop[grant_id_r]);
    if (grant_id_r == port_idx_t'(N_PORTS - 1)) begin
      ptr_next_s = 4'd0;
    end else begin
      ptr_next_s = grant_id_r + 4'd1;
    end
  end

`ifdef PORT_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] hold_cnt_r;
  logic          timeout_err_r;
  logic          expire_s;

  // Watchdog fires on the last permitted HOLD cycle; a normal packet end wins.
  always_comb begin
    expire_s = (hold_cnt_r == TW'(TIMEOUT_CYC - 1));
  end

  // Scheduler FSM with watchdog; all outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      grant_r       <= '0;
      grant_id_r    <= 4'd0;
      busy_r        <= 1'b0;
      ptr_r         <= 4'd0;
      hold_cnt_r    <= '0;
      timeout_err_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          timeout_err_r <= 1'b0;
          hold_cnt_r    <= '0;
          if (|request) begin
            grant_r    <= pick_onehot_s;
            grant_id_r <= pick_index_s;
            busy_r     <= 1'b1;
            state_r    <= HOLD;
          end else begin
            state_r    <= IDLE;
          end
        end
        HOLD: begin
          if (pkt_done_s || expire_s) begin
            grant_r       <= '0;
            grant_id_r    <= 4'd0;
            busy_r        <= 1'b0;
            ptr_r         <= ptr_next_s;
            timeout_err_r <= ~pkt_done_s;
            hold_cnt_r    <= '0;
            state_r       <= RELEASE;
          end else begin
            hold_cnt_r    <= hold_cnt_r + TW'(1);
            state_r       <= HOLD;
          end
        end
        RELEASE: begin
          timeout_err_r <= 1'b0;
          state_r       <= IDLE;
        end
        default: begin
          grant_r       <= '0;
          grant_id_r    <= 4'd0;
          busy_r        <= 1'b0;
          timeout_err_r <= 1'b0;
          hold_cnt_r    <= '0;
          state_r       <= IDLE;
        end
      endcase
    end
  end

  assign timeout_err = timeout_err_r;
`else
  // Scheduler FSM without watchdog; HOLD ends only at packet end.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      grant_r    <= '0;
      grant_id_r <= 4'd0;
      busy_r     <= 1'b0;
      ptr_r      <= 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (|request) begin
            grant_r    <= pick_onehot_s;
            grant_id_r <= pick_index_s;
            busy_r     <= 1'b1;
            state_r    <= HOLD;
          end else begin
            state_r    <= IDLE;
          end
        end
        HOLD: begin
          if (pkt_done_s) begin
            grant_r    <= '0;
            grant_id_r <= 4'd0;
            busy_r     <= 1'b0;
            ptr_r      <= ptr_next_s;
            state_r    <= RELEASE;
          end else begin
            state_r    <= HOLD;
          end
        end
        RELEASE: begin
          state_r <= IDLE;
        end
        default: begin
          grant_r    <= '0;
          grant_id_r <= 4'd0;
          busy_r     <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  assign timeout_err = 1'b0;
`endif

  assign grant    = grant_r;
  assign grant_id = grant_id_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_port_scheduler.sv
// Self-checking bench for port_scheduler: directed scenarios plus random
// traffic against a packet-level reference model.
module tb_port_scheduler;

  localparam int NP = 16;
  localparam int TO = 8;

  logic          clk;
  logic          reset_n;
  logic [NP-1:0] request;
  logic [NP-1:0] eop;
  logic          ready;
  logic [NP-1:0] grant;
  logic [3:0]    grant_id;
  logic          busy;
  logic          timeout_err;

  int n_checks;
  int n_fail;

  // Reference model: who owns the port, whether we are in the release gap,
  // where the next search starts, and how long the owner has held.
  int m_owner;
  bit m_gap;
  int m_ptr;
  int m_held;
  bit m_to;

`ifdef PORT_SCHED_TIMEOUT_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  port_scheduler #(.N_PORTS(NP), .TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .request     (request),
    .eop         (eop),
    .ready       (ready),
    .grant       (grant),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_gap   = 1'b0;
    m_ptr   = 0;
    m_held  = 0;
    m_to    = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit done;
    bit expire;
    m_to = 1'b0;
    if (m_gap) begin
      m_gap = 1'b0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < NP; k++) begin
        int p;
        p = (m_ptr + k) % NP;
        if (m_owner < 0 && request[p]) begin
          m_owner = p;
          m_held  = 0;
        end
      end
    end else begin
      m_held = m_held + 1;
      done   = !request[m_owner] || (ready && eop[m_owner]);
      expire = WD_EN && (m_held >= TO);
      if (done || expire) begin
        m_ptr   = (m_owner + 1) % NP;
        m_to    = !done;
        m_owner = -1;
        m_gap   = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    logic [NP-1:0] eg;
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    check("grant", 32'(grant), 32'(eg));
    check("grant_id", 32'(grant_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    check("busy", 32'(busy), 32'(m_owner >= 0));
    check("timeout_err", 32'(timeout_err), 32'(m_to));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check("rst_grant_async", 32'(grant), 32'd0);
    check("rst_busy_async", 32'(busy), 32'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    compare_all();
    reset_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    request  = '0;
    eop      = '0;
    ready    = 1'b0;
    reset_n  = 1'b0;
    model_reset();
    #12;
    do_reset();

    // Idle with no request stays idle
    tick();
    check("idle_no_req", 32'(grant), 32'd0);

    // Basic grant, eop release, next grant moves on
    request = 16'h000F; ready = 1'b1;
    tick();
    check("basic_grant", 32'(grant), 32'h0001);
    check("basic_busy", 32'(busy), 32'd1);
    eop = 16'h0001;
    tick();
    check("basic_release", 32'(grant), 32'd0);
    eop = '0;
    tick();
    tick();
    check("basic_next", 32'(grant), 32'h0002);
    request = '0;
    tick(); tick(); tick();

    // Drive pointer to 15, then check wrap-around
    request = 16'h4000; eop = 16'h4000;
    tick(); tick(); tick();
    request = 16'h8001; eop = '0;
    tick();
    check("wrap_first", 32'(grant), 32'h8000);
    eop = 16'h8000;
    tick();
    eop = '0;
    tick(); tick();
    check("wrap_second", 32'(grant_id), 32'd0);
    check("wrap_second_g", 32'(grant), 32'h0001);
    request = '0;
    tick(); tick(); tick();

    // Backpressure: eop with ready low holds the grant
    do_reset();
    request = 16'h0008; ready = 1'b1;
    tick();
    ready = 1'b0; eop = 16'h0008;
    tick(); tick(); tick();
    check("bp_hold", 32'(grant), 32'h0008);
    ready = 1'b1;
    tick();
    check("bp_release", 32'(grant), 32'd0);
    eop = '0; request = '0;
    tick();

    // Request drop mid-packet, eop on a waiting port ignored
    request = 16'h0020;
    tick();
    check("drop_grant5", 32'(grant), 32'h0020);
    request = 16'h0040; eop = 16'h0040;
    tick();
    check("drop_release", 32'(busy), 32'd0);
    eop = '0;
    tick(); tick();
    check("drop_grant6", 32'(grant), 32'h0040);
    tick(); tick();
    check("drop_grant6_hold", 32'(grant), 32'h0040);
    request = '0;
    tick(); tick(); tick();

    // Reset mid-packet drops the grant immediately
    request = 16'h0004;
    tick();
    check("pre_rst_grant", 32'(grant), 32'h0004);
    @(negedge clk);
    do_reset();
    tick();
    check("post_rst_grant", 32'(grant), 32'h0004);

    // Watchdog (or indefinite hold) with port 2 never ending its packet
    for (int i = 0; i < 12; i++) tick();
    if (WD_EN) begin
      check("wd_regrant", 32'(grant), 32'h0004);
    end else begin
      check("hold_forever", 32'(grant), 32'h0004);
    end
    request = '0;
    tick(); tick(); tick();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) request = NP'($urandom);
      eop   = NP'($urandom) & NP'($urandom);
      ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/port_scheduler.md
PORT_SCHEDULER -- requirements
Module: port_scheduler

Interface
REQ-001 SHALL have parameter N_PORTS, default 16, number of requesting input ports.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1024, maximum cycles one grant is held (used only under REQ-026).
REQ-003 SHALL have port clk, input, 1, single clock; all state is updated on the rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port request, input, N_PORTS, per-input request for this output port.
REQ-006 SHALL have port eop, input, N_PORTS, per-input end-of-packet flag for the current beat.
REQ-007 SHALL have port ready, input, 1, output port accepts a beat this cycle.
REQ-008 SHALL have port grant, output, N_PORTS, one-hot registered grant.
REQ-009 SHALL have port grant_id, output, 4, binary index of the granted port; 0 when no grant.
REQ-010 SHALL have port busy, output, 1, high while any grant bit is set.
REQ-011 SHALL have port timeout_err, output, 1, one-cycle pulse on forced release; tied 0 when REQ-026 is compiled out.

Function
REQ-012 SHALL use a three-state FSM: IDLE, HOLD, RELEASE.
REQ-013 In IDLE with request nonzero, SHALL set grant to the first requesting port at or after the round-robin pointer, wrapping 15->0, and enter HOLD on the next edge; request-to-grant latency SHALL be 1 cycle.
REQ-014 In IDLE with request zero, SHALL keep grant=0 and stay in IDLE.
REQ-015 In HOLD, grant SHALL stay constant regardless of other request changes; there is no preemption.
REQ-016 In HOLD, a beat SHALL be accepted when request[grant_id] && ready.
REQ-017 In HOLD, SHALL enter RELEASE when an accepted beat has eop[grant_id]=1, or when request[grant_id] deasserts.
REQ-018 eop on non-granted ports SHALL be ignored.
REQ-019 In RELEASE, SHALL drive grant=0 and busy=0 for exactly one cycle, load pointer = grant_id+1 mod N_PORTS, then enter IDLE.
REQ-020 grant SHALL always be one-hot or zero, and grant_id/busy SHALL be consistent with grant in the same cycle.
REQ-021 A requester that stays asserted SHALL be granted within N_PORTS arbitration rounds, which makes the scheduler starvation-free.

Reset
REQ-022 On reset_n low, SHALL asynchronously force the following: FSM=IDLE, grant=0, grant_id=0, busy=0, timeout_err=0, pointer=0, timeout counter=0.
REQ-023 Reset asserted mid-packet SHALL drop the grant immediately, with no RELEASE cycle.
REQ-024 After reset_n rises, the first arbitration SHALL occur on the first edge at which any request is high, with the search starting at port 0.

Configuration
REQ-025 Macro PORT_SCHED_TIMEOUT_EN SHALL select the watchdog feature.
REQ-026 With PORT_SCHED_TIMEOUT_EN defined, the block SHALL behave as follows:
- Count cycles in HOLD; the counter clears on entry to HOLD.
- When the count reaches TIMEOUT_CYC, force RELEASE and pulse timeout_err for 1 cycle, coincident with the RELEASE cycle.
- Pointer advance is identical to REQ-019.
REQ-027 Without PORT_SCHED_TIMEOUT_EN, the block SHALL contain no counter, timeout_err SHALL be constant 0, and HOLD is left only per REQ-017.

Structure
REQ-028 A shared package router_pkg SHALL hold the following:
- the FSM state enum (IDLE, HOLD, RELEASE);
- the constant N_PORTS_DEF=16;
- the port-index typedef (4-bit).
REQ-029 Round-robin selection SHALL live in one combinational sub-module rr_pick (inputs request and pointer; outputs one-hot and index).

Verification
REQ-030 Reset then request=16'h000F with ready=1 -> grant=16'h0001 one cycle later and busy=1; eop[0] beat -> one RELEASE cycle with grant=0; next grant=16'h0002.
REQ-031 request=16'h8001 with pointer=15 -> grant=16'h8000; after eop[15] and RELEASE, grant=16'h0001 (wrap-around).
REQ-032 Granted port 3 with ready=0 and eop[3]=1 -> grant held; ready=1 on a later cycle -> RELEASE on the following edge.
REQ-033 Granted port 5 drops request[5] mid-packet while port 6 requests -> RELEASE, then grant=16'h0040; eop on port 6 before its grant is ignored.
REQ-034 reset_n low while grant=16'h0004 -> grant=0 and busy=0 asynchronously; after release of reset with request=16'h0004 -> grant=16'h0004.
REQ-035 With PORT_SCHED_TIMEOUT_EN and TIMEOUT_CYC=8, port 2 holds with no eop -> after 8 HOLD cycles timeout_err pulses 1 cycle and grant=0; without the macro, grant is held indefinitely.
